floo_axis_noc_bridge_vc_multi: RTL and testbench

//  Generalised NoC<->AXIS bridge: carries NumVirtChan independent FlooNoC channels over one AXIS link.
//  Per-VC credit-based flow control; credits are piggybacked on data or sent in credit-only packets.

---
 rtl/noc_bridge_pkg.sv | 50 +++++
 rtl/floo_vc_credit_ctrl.sv | 51 +++++
 rtl/floo_axis_noc_bridge_vc_multi.sv | 222 ++++++++++++++++++++++
 tb/tb_floo_axis_noc_bridge_vc_multi.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/noc_bridge_pkg.sv
// ============================================================================
// Package  : noc_bridge_pkg
// Brief    : AXIS packet types and field-width helpers for the NoC<->AXIS bridge
// Revision : 1.0
// ============================================================================
`default_nettype none

package noc_bridge_pkg;

   localparam int NUM_VIRT_CHAN_DEFAULT = 2;
   localparam int AXIS_DATA_W           = 128;
   localparam int AXIS_USER_W           = 16;
   localparam int AXIS_ID_W             = 8;
   localparam int AXIS_DEST_W           = 8;

   function automatic int cred_width(input int num_cred);
      return $clog2(num_cred + 1);
   endfunction

   function automatic int chan_width(input int num_chan);
      return (num_chan > 1) ? $clog2(num_chan) : 1;
   endfunction

   // user = {.., data_valid, cred_chan, cred_cnt}; data = {data_chan, flit}
   function automatic int user_data_valid_bit(input int cred_w, input int chan_w);
      return cred_w + chan_w;
   endfunction

   typedef struct packed {
      logic [AXIS_DATA_W-1:0]   data;
      logic [AXIS_DATA_W/8-1:0] strb;
      logic [AXIS_DATA_W/8-1:0] keep;
      logic                     last;
      logic [AXIS_ID_W-1:0]     id;
      logic [AXIS_DEST_W-1:0]   dest;
      logic [AXIS_USER_W-1:0]   user;
   } axis_t_t;

   typedef struct packed {
      axis_t_t t;
      logic    tvalid;
   } axis_req_t;

   typedef struct packed {
      logic tready;
   } axis_rsp_t;

endpackage

`default_nettype wire

// File: rtl/floo_vc_credit_ctrl.sv
// ============================================================================
// Module   : floo_vc_credit_ctrl
// Brief    : Per-VC transmit credit counter and pending receive-credit counter
// Revision : 1.0
// ============================================================================
`default_nettype none

module floo_vc_credit_ctrl
   import noc_bridge_pkg::*;
#(
   parameter int NumCred = 8,
   parameter int CredW   = cred_width(NumCred)
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             tx_dec_i,
   input  logic [CredW-1:0] tx_add_i,
   input  logic             rx_inc_i,
   input  logic             rx_clr_i,
   output logic [CredW-1:0] tx_cred_o,
   output logic [CredW-1:0] rx_pend_o
);

   localparam logic [CredW:0] c_max_cred = (CredW+1)'(NumCred);

   logic [CredW-1:0] r_tx_cred;
   logic [CredW-1:0] r_rx_pend;
   logic [CredW:0]   w_tx_next;

   // Returned credits and a same-cycle send are netted in one update.
   assign w_tx_next = {1'b0, r_tx_cred} + {1'b0, tx_add_i} - (CredW+1)'(tx_dec_i);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_tx_cred <= CredW'(NumCred);
         r_rx_pend <= '0;
      end else begin
         r_tx_cred <= w_tx_next[CredW-1:0];
         r_rx_pend <= rx_clr_i ? CredW'(rx_inc_i) : r_rx_pend + CredW'(rx_inc_i);
      end
   end

   assign tx_cred_o = r_tx_cred;
   assign rx_pend_o = r_rx_pend;

   a_cred_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
      w_tx_next <= c_max_cred);

endmodule

`default_nettype wire

// File: rtl/floo_axis_noc_bridge_vc_multi.sv
// ============================================================================
// Module   : floo_axis_noc_bridge_vc_multi
// Brief    : N-VC FlooNoC <-> AXIS bridge with per-VC credit-based flow control
// Revision : 1.0
// ============================================================================
`default_nettype none

module floo_axis_noc_bridge_vc_multi
   import noc_bridge_pkg::*;
#(
   parameter int NumVirtChan     = NUM_VIRT_CHAN_DEFAULT,
   parameter int FlitWidth       = 64,
   parameter int NumCred         = 8,
   parameter int ForceSendThresh = 4,
   parameter int CredTimeout     = 64
) (
   input  logic                             clk_i,
   input  logic                             rst_ni,
   input  logic [NumVirtChan-1:0]           noc_in_valid_i,
   output logic [NumVirtChan-1:0]           noc_in_ready_o,
   input  logic [NumVirtChan*FlitWidth-1:0] noc_in_data_i,
   output logic [NumVirtChan-1:0]           noc_out_valid_o,
   input  logic [NumVirtChan-1:0]           noc_out_ready_i,
   output logic [NumVirtChan*FlitWidth-1:0] noc_out_data_o,
   output axis_req_t                        axis_out_req_o,
   input  axis_rsp_t                        axis_out_rsp_i,
   input  axis_req_t                        axis_in_req_i,
   output axis_rsp_t                        axis_in_rsp_o,
   output logic                             err_chan_o
);

   localparam int c_chan_w  = chan_width(NumVirtChan);
   localparam int c_cred_w  = cred_width(NumCred);
   localparam int c_tmr_w   = (CredTimeout > 0) ? $clog2(CredTimeout + 1) : 1;
   localparam int c_ptr_w   = (NumCred > 1) ? $clog2(NumCred) : 1;
   localparam int c_dchan_w = AXIS_DATA_W - FlitWidth;
   localparam int c_dv_bit  = user_data_valid_bit(c_cred_w, c_chan_w);
   localparam logic [c_chan_w:0] c_nvc = (c_chan_w+1)'(NumVirtChan);

   logic [NumVirtChan-1:0][FlitWidth-1:0] w_in_flits, w_out_flits;
   logic [NumVirtChan-1:0][c_cred_w-1:0]  w_tx_cred, w_rx_pend, w_tx_add;
   logic [NumVirtChan-1:0][c_chan_w-1:0]  w_rr_idx;
   logic [NumVirtChan-1:0] w_elig, w_grant, w_tx_dec, w_rx_inc, w_rx_clr, w_fifo_rdy;
   logic [c_chan_w-1:0]    r_rr_ptr, w_grant_idx, w_pick_idx;
   logic [c_cred_w-1:0]    w_max_pend;
   logic [c_tmr_w-1:0]     r_timer;
   logic                   w_any_grant, w_timeout, w_cred_only, w_push, w_out_ready, w_out_pop;
   axis_t_t                w_pkt;
   axis_t_t                r_out_q [2];
   logic                   r_out_wr, r_out_rd, r_err;
   logic [1:0]             r_out_cnt;

   assign w_in_flits     = noc_in_data_i;
   assign noc_out_data_o = w_out_flits;

   // ---------------- TX: round-robin arbitration and credit pick ----------------
   always_comb begin
      w_grant     = '0;
      w_grant_idx = '0;
      w_any_grant = 1'b0;
      for (int i = 0; i < NumVirtChan; i++) begin
         if (!w_any_grant && w_elig[w_rr_idx[i]]) begin
            w_any_grant = 1'b1;
            w_grant_idx = w_rr_idx[i];
         end
      end
      if (w_any_grant) w_grant[w_grant_idx] = 1'b1;
   end

   always_comb begin
      w_pick_idx = '0;
      w_max_pend = w_rx_pend[0];
      for (int i = 1; i < NumVirtChan; i++) begin
         if (w_rx_pend[i] > w_max_pend) begin
            w_max_pend = w_rx_pend[i];
            w_pick_idx = c_chan_w'(i);
         end
      end
   end

   assign w_timeout   = (CredTimeout != 0) && (r_timer == c_tmr_w'(CredTimeout));
   assign w_cred_only = !w_any_grant && ((w_max_pend >= c_cred_w'(ForceSendThresh)) || w_timeout);
   assign w_out_ready = (r_out_cnt != 2'd2);
   assign w_push      = (w_any_grant || w_cred_only) && w_out_ready;
   assign noc_in_ready_o = w_grant & {NumVirtChan{w_out_ready}};
   assign w_tx_dec    = noc_in_valid_i & noc_in_ready_o;

   always_comb begin
      w_pkt      = '0;
      w_pkt.strb = '1;
      if (w_any_grant) begin
         w_pkt.data[FlitWidth-1:0]           = w_in_flits[w_grant_idx];
         w_pkt.data[AXIS_DATA_W-1:FlitWidth] = c_dchan_w'(w_grant_idx);
      end
      w_pkt.user[c_dv_bit]              = w_any_grant;
      w_pkt.user[c_cred_w +: c_chan_w]  = w_pick_idx;
      w_pkt.user[c_cred_w-1:0]          = w_max_pend;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_rr_ptr <= '0;
         r_timer  <= '0;
      end else begin
         if (w_any_grant && w_out_ready)
            r_rr_ptr <= (w_grant_idx == c_chan_w'(NumVirtChan - 1)) ? '0 : w_grant_idx + c_chan_w'(1);
         if (w_push || (w_max_pend == '0))
            r_timer <= '0;
         else if (r_timer != c_tmr_w'(CredTimeout))
            r_timer <= r_timer + c_tmr_w'(1);
      end
   end

   // ---------------- AXIS output: two-entry register ----------------
   assign w_out_pop = (r_out_cnt != 2'd0) && axis_out_rsp_i.tready;

   always_ff @(posedge clk_i) begin
      if (w_push) r_out_q[r_out_wr] <= w_pkt;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_out_wr  <= 1'b0;
         r_out_rd  <= 1'b0;
         r_out_cnt <= 2'd0;
      end else begin
         if (w_push)    r_out_wr <= ~r_out_wr;
         if (w_out_pop) r_out_rd <= ~r_out_rd;
         r_out_cnt <= r_out_cnt + 2'(w_push) - 2'(w_out_pop);
      end
   end

   always_comb begin
      axis_out_req_o        = '0;
      axis_out_req_o.t      = r_out_q[r_out_rd];
      axis_out_req_o.tvalid = (r_out_cnt != 2'd0);
   end

   // ---------------- RX: decode, credit return, per-VC FIFOs ----------------
   logic [c_dchan_w-1:0] w_in_dchan;
   logic [c_chan_w-1:0]  w_in_cchan, w_dchan_lo;
   logic [c_cred_w-1:0]  w_in_ccnt;
   logic                 w_in_dv, w_dchan_ok, w_cchan_ok, w_rx_hs, w_unused_in;

   assign w_in_dchan = axis_in_req_i.t.data[AXIS_DATA_W-1:FlitWidth];
   assign w_dchan_lo = w_in_dchan[c_chan_w-1:0];
   assign w_in_dv    = axis_in_req_i.t.user[c_dv_bit];
   assign w_in_cchan = axis_in_req_i.t.user[c_cred_w +: c_chan_w];
   assign w_in_ccnt  = axis_in_req_i.t.user[c_cred_w-1:0];
   assign w_dchan_ok = (w_in_dchan < c_dchan_w'(NumVirtChan));
   assign w_cchan_ok = ({1'b0, w_in_cchan} < c_nvc);
   assign axis_in_rsp_o.tready = !w_in_dv || !w_dchan_ok || w_fifo_rdy[w_dchan_lo];
   assign w_rx_hs    = axis_in_req_i.tvalid && axis_in_rsp_o.tready;
   assign w_unused_in = ^{axis_in_req_i.t.strb, axis_in_req_i.t.keep, axis_in_req_i.t.last,
                          axis_in_req_i.t.id, axis_in_req_i.t.dest,
                          axis_in_req_i.t.user[AXIS_USER_W-1:c_dv_bit+1]};

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)                              r_err <= 1'b0;
      else if (w_rx_hs && w_in_dv && !w_dchan_ok) r_err <= 1'b1;
   end
   assign err_chan_o = r_err;

   for (genvar c = 0; c < NumVirtChan; c++) begin : g_vc
      logic [FlitWidth-1:0] r_mem [NumCred];
      logic [c_ptr_w-1:0]   r_wr, r_rd;
      logic [c_cred_w-1:0]  r_cnt;
      logic [c_chan_w:0]    w_rr_sum;
      logic                 w_hit, w_fpush, w_fpop;

      assign w_rr_sum    = {1'b0, r_rr_ptr} + (c_chan_w+1)'(c);
      assign w_rr_idx[c] = (w_rr_sum >= c_nvc) ? c_chan_w'(w_rr_sum - c_nvc) : w_rr_sum[c_chan_w-1:0];
      assign w_elig[c]   = noc_in_valid_i[c] && (w_tx_cred[c] != '0);

      assign w_hit   = axis_in_req_i.tvalid && w_in_dv && w_dchan_ok && (w_dchan_lo == c_chan_w'(c));
      assign w_fpush = w_hit && w_rx_hs;
      assign w_fpop  = noc_out_valid_o[c] && noc_out_ready_i[c];
      assign w_fifo_rdy[c]      = (r_cnt != c_cred_w'(NumCred));
      assign noc_out_valid_o[c] = (r_cnt != '0);
      assign w_out_flits[c]     = r_mem[r_rd];
      assign w_rx_inc[c] = w_fpop;
      assign w_rx_clr[c] = w_push && (w_pick_idx == c_chan_w'(c));
      assign w_tx_add[c] = (w_rx_hs && w_cchan_ok && (w_in_cchan == c_chan_w'(c))) ? w_in_ccnt : '0;

      always_ff @(posedge clk_i) begin
         if (w_fpush) r_mem[r_wr] <= axis_in_req_i.t.data[FlitWidth-1:0];
      end

      always_ff @(posedge clk_i or negedge rst_ni) begin
         if (!rst_ni) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
         end else begin
            if (w_fpush) r_wr <= (r_wr == c_ptr_w'(NumCred - 1)) ? '0 : r_wr + c_ptr_w'(1);
            if (w_fpop)  r_rd <= (r_rd == c_ptr_w'(NumCred - 1)) ? '0 : r_rd + c_ptr_w'(1);
            r_cnt <= r_cnt + c_cred_w'(w_fpush) - c_cred_w'(w_fpop);
         end
      end

      floo_vc_credit_ctrl #(
         .NumCred (NumCred),
         .CredW   (c_cred_w)
      ) u_cred (
         .clk_i     (clk_i),
         .rst_ni    (rst_ni),
         .tx_dec_i  (w_tx_dec[c]),
         .tx_add_i  (w_tx_add[c]),
         .rx_inc_i  (w_rx_inc[c]),
         .rx_clr_i  (w_rx_clr[c]),
         .tx_cred_o (w_tx_cred[c]),
         .rx_pend_o (w_rx_pend[c])
      );

      // A sender honouring credits never targets a full FIFO.
      a_fifo_full: assert property (@(posedge clk_i) disable iff (!rst_ni)
         !(w_hit && !w_fifo_rdy[c]));
   end

endmodule

`default_nettype wire

// File: tb/tb_floo_axis_noc_bridge_vc_multi.sv
// ============================================================================
// Module   : tb_floo_axis_noc_bridge_vc_multi
// Brief    : Directed self-checking bench for the 4-VC NoC<->AXIS bridge
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_floo_axis_noc_bridge_vc_multi;
   import noc_bridge_pkg::*;

   logic           clk = 1'b0;
   logic           rst_ni;
   logic [3:0]     nin_valid, nin_ready, nout_valid, nout_ready;
   logic [255:0]   nin_data, nout_data;
   axis_req_t      out_req, in_req;
   axis_rsp_t      out_rsp, in_rsp;
   logic           err;

   int n_pass   = 0;
   int n_checks = 0;
   int cyc      = 0;
   int nin_hs   = 0;

   logic [127:0] ob_data[$];
   logic [15:0]  ob_user[$];
   int           ob_cyc[$];
   logic [63:0]  pop_flit[$];
   int           pop_chan[$];
   int           pop_cyc[$];

   floo_axis_noc_bridge_vc_multi #(
      .NumVirtChan     (4),
      .FlitWidth       (64),
      .NumCred         (8),
      .ForceSendThresh (4),
      .CredTimeout     (64)
   ) dut (
      .clk_i           (clk),
      .rst_ni          (rst_ni),
      .noc_in_valid_i  (nin_valid),
      .noc_in_ready_o  (nin_ready),
      .noc_in_data_i   (nin_data),
      .noc_out_valid_o (nout_valid),
      .noc_out_ready_i (nout_ready),
      .noc_out_data_o  (nout_data),
      .axis_out_req_o  (out_req),
      .axis_out_rsp_i  (out_rsp),
      .axis_in_req_i   (in_req),
      .axis_in_rsp_o   (in_rsp),
      .err_chan_o      (err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   always @(negedge clk) begin
      if (rst_ni) begin
         if (out_req.tvalid && out_rsp.tready) begin
            ob_data.push_back(out_req.t.data);
            ob_user.push_back(out_req.t.user);
            ob_cyc.push_back(cyc);
         end
         for (int c = 0; c < 4; c++) begin
            if (nin_valid[c] && nin_ready[c]) nin_hs++;
            if (nout_valid[c] && nout_ready[c]) begin
               pop_chan.push_back(c);
               pop_flit.push_back(nout_data[c*64 +: 64]);
               pop_cyc.push_back(cyc);
            end
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic clear_logs();
      ob_data.delete(); ob_user.delete(); ob_cyc.delete();
      pop_flit.delete(); pop_chan.delete(); pop_cyc.delete();
      nin_hs = 0;
   endtask

   task automatic send_pkt(input logic [63:0] chan, input logic [63:0] flit, input logic [15:0] user);
      in_req          = '0;
      in_req.tvalid   = 1'b1;
      in_req.t.data   = {chan, flit};
      in_req.t.user   = user;
   endtask

   initial begin
      rst_ni     = 1'b0;
      nin_valid  = '0;
      nin_data   = '0;
      nout_ready = '0;
      in_req     = '0;
      out_rsp.tready = 1'b1;
      tick(3);
      chk("rst_tvalid", 128'(out_req.tvalid), 128'd0);
      chk("rst_nin_ready", 128'(nin_ready), 128'd0);
      chk("rst_nout_valid", 128'(nout_valid), 128'd0);
      chk("rst_err", 128'(err), 128'd0);
      rst_ni = 1'b1;
      tick(2);

      // Round-robin over four always-valid VCs
      clear_logs();
      nin_data  = {64'h1003, 64'h1002, 64'h1001, 64'h1000};
      nin_valid = 4'hF;
      tick(8);
      nin_valid = 4'h0;
      tick(4);
      for (int i = 0; i < 8; i++)
         chk("arb_beat", ob_data[i], {64'(i % 4), 64'h1000 + 64'(i % 4)});
      chk("arb_no_bubble", 128'(ob_cyc[7] - ob_cyc[0]), 128'd7);

      // Reset mid-operation restores full credits
      rst_ni = 1'b0;
      tick(2);
      chk("rst2_tvalid", 128'(out_req.tvalid), 128'd0);
      rst_ni = 1'b1;
      tick(2);

      // Credit exhaustion on VC0
      clear_logs();
      nin_data[63:0] = 64'hA5A5;
      nin_valid = 4'h1;
      tick(20);
      chk("exh_handshakes", 128'(nin_hs), 128'd8);
      chk("exh_ready_low", 128'(nin_ready), 128'd0);
      chk("exh_beats", 128'(ob_data.size()), 128'd8);
      chk("exh_user", 128'(ob_user[7]), 128'h0040);

      // Credit-only packet returns 8 credits to VC0
      send_pkt(64'd0, 64'd0, 16'h0008);
      #1;
      chk("cred_rx_tready", 128'(in_rsp.tready), 128'd1);
      tick(1);
      in_req = '0;
      tick(20);
      chk("cred_refill_hs", 128'(nin_hs), 128'd16);
      nin_valid = 4'h0;
      tick(3);

      // RX on VC2, then drain triggers threshold credit-only packet
      clear_logs();
      for (int i = 0; i < 4; i++) begin
         send_pkt(64'd2, 64'hB000 + 64'(i), 16'h0040);
         tick(1);
      end
      in_req = '0;
      tick(1);
      chk("rx_valid_vc2", 128'(nout_valid), 128'h4);
      chk("rx_head_vc2", 128'(nout_data[191:128]), 128'hB000);
      nout_ready = 4'hF;
      tick(10);
      for (int i = 0; i < 4; i++)
         chk("rx_pop_vc2", {64'(pop_chan[i]), pop_flit[i]}, {64'd2, 64'hB000 + 64'(i)});
      chk("thr_pkt_count", 128'(ob_user.size()), 128'd1);
      chk("thr_pkt_user", 128'(ob_user[0]), 128'h0024);

      // Single pending credit on VC1 returned by timeout
      clear_logs();
      send_pkt(64'd1, 64'hC1, 16'h0040);
      tick(1);
      in_req = '0;
      tick(80);
      chk("tmo_pop", {64'(pop_chan[0]), pop_flit[0]}, {64'd1, 64'hC1});
      chk("tmo_pkt_user", {64'(ob_user.size()), 64'(ob_user[0])}, {64'd1, 64'h0011});
      chk("tmo_delay", 128'((ob_cyc[0] - pop_cyc[0]) >= 65 && (ob_cyc[0] - pop_cyc[0]) <= 67), 128'd1);

      // Invalid data channel: consumed, dropped, sticky error
      clear_logs();
      send_pkt(64'd5, 64'hDEAD, 16'h0040);
      #1;
      chk("bad_tready", 128'(in_rsp.tready), 128'd1);
      tick(1);
      in_req = '0;
      tick(3);
      chk("bad_err", 128'(err), 128'd1);
      chk("bad_no_pop", 128'(pop_flit.size()), 128'd0);
      chk("bad_no_valid", 128'(nout_valid), 128'd0);
      tick(5);
      chk("bad_err_sticky", 128'(err), 128'd1);
      rst_ni = 1'b0;
      tick(2);
      chk("bad_err_reset", 128'(err), 128'd0);
      rst_ni = 1'b1;
      tick(2);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

`default_nettype wire
